// File: rtl/sd1011_mealy.sv
// sd1011_mealy: serial "1011" sequence detector, Mealy style.
// dout is a combinational function of the present state and din.
// It flags the bit that completes "1011" during that bit's own cycle,
// before the clock edge that samples it.
// OVERLAP=1 lets the trailing '1' of a match begin the next match.
// OVERLAP=0 restarts from idle after every match.
module sd1011_mealy #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  // Progress through the pattern, named by the suffix matched so far.
  typedef enum logic [1:0] {
    S0   = 2'b00,
    S1   = 2'b01,
    S10  = 2'b10,
    S101 = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;

  // State register; an asynchronous reset returns to idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. Only an explicit din==1 advances on a '1'. An unknown
  // din takes the '0' branch, so the register always loads a known
  // state. Illegal encodings fall back to idle.
  always_comb begin
    state_nxt = S0;
    case (state)
      S0: begin
        if (din == 1'b1) state_nxt = S1;
        else             state_nxt = S0;
      end
      S1: begin
        if (din == 1'b1) state_nxt = S1;
        else             state_nxt = S10;
      end
      S10: begin
        if (din == 1'b1) state_nxt = S101;
        else             state_nxt = S0;
      end
      S101: begin
        // A '0' here leaves the suffix "10", which is still a valid prefix.
        if (din == 1'b1) state_nxt = OVERLAP ? S1 : S0;
        else             state_nxt = S10;
      end
      default: state_nxt = S0;
    endcase
  end

  // Detect flag: "101" seen and the bit now on din is the closing '1'.
  // The flag is held low for as long as reset is asserted.
  always_comb begin
    dout = 1'b0;
    if (!reset && (state == S101) && (din == 1'b1)) begin
      dout = 1'b1;
    end
  end

endmodule

// File: tb/tb_sd1011_mealy.sv
// tb_sd1011_mealy: directed and randomized checks of sd1011_mealy.
// The reference model is a per-instance history of sampled bits.
module tb_sd1011_mealy;

  logic clk;
  logic reset;
  logic din;
  logic dout_ov;
  logic dout_no;

  int compared;
  int mismatched;

  // Bits sampled since the last reset (and, for the non-overlap model,
  // since the last match).
  bit hist_ov[$];
  bit hist_no[$];

  sd1011_mealy #(.OVERLAP(1'b1)) dut_ov (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout_ov)
  );

  sd1011_mealy #(.OVERLAP(1'b0)) dut_no (
    .clk  (clk),
    .reset(reset),
    .din  (din),
    .dout (dout_no)
  );

  // 10 ns clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // True when the last three sampled bits are 1,0,1.
  function automatic bit tail101(input bit q[$]);
    int n;
    n = q.size();
    if (n < 3) return 1'b0;
    return (q[n-3] == 1'b1) && (q[n-2] == 1'b0) && (q[n-1] == 1'b1);
  endfunction

  // Drive one bit, sample both outputs mid-cycle, then advance the model.
  task automatic drive_bit(input logic b, output logic o_ov, output logic o_no,
                           output logic e_ov, output logic e_no);
    @(negedge clk);
    din = b;
    #1;
    e_ov = tail101(hist_ov) && (b === 1'b1);
    e_no = tail101(hist_no) && (b === 1'b1);
    o_ov = dout_ov;
    o_no = dout_no;
    @(posedge clk);
    hist_ov.push_back(b);
    if (hist_ov.size() > 8) void'(hist_ov.pop_front());
    hist_no.push_back(b);
    if (e_no) hist_no.delete();
    if (hist_no.size() > 8) void'(hist_no.pop_front());
  endtask

  // Assert reset off-edge, hold it across one rising edge, release it.
  task automatic apply_reset(input logic din_during);
    @(negedge clk);
    #2;
    reset = 1'b1;
    din   = din_during;
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    din   = 1'b0;
    hist_ov.delete();
    hist_no.delete();
  endtask

  // Send bits (MSB first), check every bit and the pulse totals.
  task automatic run_seq(input string name, input logic [15:0] bits, input int n,
                         input int exp_ov, input int exp_no);
    logic o_ov, o_no, e_ov, e_no;
    logic [15:0] v;
    int p_ov, p_no;
    v = bits;
    p_ov = 0;
    p_no = 0;
    for (int i = n - 1; i >= 0; i--) begin
      drive_bit(v[i], o_ov, o_no, e_ov, e_no);
      compared++;
      if (o_ov !== e_ov) begin
        mismatched++;
        $display("FAIL %s bit%0d ov: dout=%b expected %b", name, n - 1 - i, o_ov, e_ov);
      end
      compared++;
      if (o_no !== e_no) begin
        mismatched++;
        $display("FAIL %s bit%0d no: dout=%b expected %b", name, n - 1 - i, o_no, e_no);
      end
      if (o_ov === 1'b1) p_ov++;
      if (o_no === 1'b1) p_no++;
    end
    compared++;
    if (p_ov != exp_ov) begin
      mismatched++;
      $display("FAIL %s pulses ov: got %0d expected %0d", name, p_ov, exp_ov);
    end
    compared++;
    if (p_no != exp_no) begin
      mismatched++;
      $display("FAIL %s pulses no: got %0d expected %0d", name, p_no, exp_no);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    din   = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din = ~din;
      #1;
      compared++;
      if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
        mismatched++;
        $display("FAIL reset_hold t%0d: dout=%b/%b expected 0/0", i, dout_ov, dout_no);
      end
      #1;
    end
    reset = 1'b0;
    din   = 1'b1;
    #1;
    compared++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_idle: dout=%b/%b expected 0/0", dout_ov, dout_no);
    end
    #1;
    din = 1'b0;
    hist_ov.delete();
    hist_no.delete();
  endtask

  task automatic test_basic();
    run_seq("basic", 16'b1011, 4, 1, 1);
  endtask

  task automatic test_overlap();
    run_seq("overlap", 16'b011, 3, 1, 0);
  endtask

  task automatic test_noise();
    run_seq("noise", 16'b001011, 6, 1, 1);
  endtask

  task automatic test_near_miss();
    run_seq("near_10011", 16'b10011, 5, 0, 0);
    run_seq("near_111", 16'b111, 3, 0, 0);
    run_seq("near_101011", 16'b101011, 6, 1, 1);
  endtask

  task automatic test_async_reset();
    run_seq("async_pre", 16'b101, 3, 0, 0);
    @(negedge clk);
    din = 1'b1;
    #1;
    compared++;
    if (dout_ov !== 1'b1 || dout_no !== 1'b1) begin
      mismatched++;
      $display("FAIL async_armed: dout=%b/%b expected 1/1", dout_ov, dout_no);
    end
    #1;
    reset = 1'b1;
    #1;
    compared++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      mismatched++;
      $display("FAIL async_assert: dout=%b/%b expected 0/0", dout_ov, dout_no);
    end
    @(posedge clk);
    #1;
    compared++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      mismatched++;
      $display("FAIL async_hold: dout=%b/%b expected 0/0", dout_ov, dout_no);
    end
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      mismatched++;
      $display("FAIL async_release: dout=%b/%b expected 0/0", dout_ov, dout_no);
    end
    din = 1'b0;
    hist_ov.delete();
    hist_no.delete();
    run_seq("async_single1", 16'b1, 1, 0, 0);
    run_seq("async_full", 16'b1011, 4, 1, 1);
  endtask

  task automatic test_x_under_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    din   = 1'bx;
    #1;
    compared++;
    if (dout_ov !== 1'b0 || dout_no !== 1'b0) begin
      mismatched++;
      $display("FAIL x_reset: dout=%b/%b expected 0/0", dout_ov, dout_no);
    end
    @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b0;
    din   = 1'b0;
    hist_ov.delete();
    hist_no.delete();
    run_seq("x_after", 16'b1011, 4, 1, 1);
  endtask

  task automatic test_random();
    logic o_ov, o_no, e_ov, e_no, b;
    int p_ov, p_no, m_ov, m_no;
    p_ov = 0; p_no = 0; m_ov = 0; m_no = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        apply_reset(1'($urandom_range(0, 1)));
      end
      b = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
      drive_bit(b, o_ov, o_no, e_ov, e_no);
      compared++;
      if (o_ov !== e_ov) begin
        mismatched++;
        $display("FAIL random%0d ov: dout=%b expected %b", i, o_ov, e_ov);
      end
      compared++;
      if (o_no !== e_no) begin
        mismatched++;
        $display("FAIL random%0d no: dout=%b expected %b", i, o_no, e_no);
      end
      if (o_ov === 1'b1) p_ov++;
      if (o_no === 1'b1) p_no++;
      if (e_ov) m_ov++;
      if (e_no) m_no++;
    end
    compared++;
    if (p_ov != m_ov || p_no != m_no) begin
      mismatched++;
      $display("FAIL random_totals: pulses %0d/%0d expected %0d/%0d", p_ov, p_no, m_ov, m_no);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_basic();
    test_overlap();
    test_noise();
    test_near_miss();
    test_async_reset();
    test_x_under_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
